// File: rtl/hd_pkg.sv
// Shared widths, mode encodings and FSM states for the hard-disk transfer controller.
package hd_pkg;

    localparam int SECTOR_W  = 4;
    localparam int TRACK_W   = 10;
    localparam int HD_ADDR_W = 14;
    localparam int HD_WORDS  = 16384;

    localparam logic MODE_LOAD  = 1'b0;
    localparam logic MODE_STORE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_WAIT,
        MEM_WR,
        MR_ADDR,
        MR_WAIT,
        HD_WR,
        DONE
    } state_t;

endpackage

// File: rtl/hd_addr_gen.sv
// 14-bit {sector, track} address register with load/increment, plus the
// end-of-disk range comparator for a requested block.
module hd_addr_gen
    import hd_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 inc,
    input  logic [HD_ADDR_W-1:0] load_addr,
    input  logic [9:0]           count,
    output logic [HD_ADDR_W-1:0] addr,
    output logic                 range_ok
);

    logic [HD_ADDR_W:0] end_addr;

    // One extra bit so a block ending exactly at the last word is still legal.
    assign end_addr = {1'b0, load_addr} + {{(HD_ADDR_W-9){1'b0}}, count};
    assign range_ok = (end_addr <= (HD_ADDR_W+1)'(HD_WORDS));

    always_ff @(posedge clock) begin
        if (reset) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_addr;
        end else if (inc) begin
            addr <= addr + HD_ADDR_W'(1);
        end
    end

endmodule

// File: rtl/hd_transfer_ctrl.sv
// Initiator for block word copies between the hard disk and word memory.
//   state   | meaning
//   IDLE    | waiting for start; addresses hold last value
//   RD_ADDR | present HD address for the next LOAD word
//   RD_WAIT | HD_LAT cycles of HD latency, capture hdDataR on the last
//   MEM_WR  | write buffered word to memory, advance addresses
//   MR_ADDR | present memory address for the next STORE word
//   MR_WAIT | MEM_LAT cycles of memory latency, capture memDataR on the last
//   HD_WR   | write buffered word to HD, advance addresses
//   DONE    | one-cycle completion pulse
module hd_transfer_ctrl
    import hd_pkg::*;
#(
    parameter int MEM_ADDR_W = 8,
    parameter int HD_LAT     = 2,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [SECTOR_W-1:0]   sectorIn,
    input  logic [TRACK_W-1:0]    trackIn,
    input  logic [MEM_ADDR_W-1:0] memBase,
    input  logic [9:0]            wordCount,
    output logic [SECTOR_W-1:0]   hdSector,
    output logic [TRACK_W-1:0]    hdTrack,
    output logic [31:0]           hdDataW,
    output logic                  hdFlag,
    input  logic [31:0]           hdDataR,
    output logic [MEM_ADDR_W-1:0] memAddr,
    output logic [31:0]           memDataW,
    output logic                  memWe,
    input  logic [31:0]           memDataR,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int MEM_SUM_W = ((MEM_ADDR_W > 10) ? MEM_ADDR_W : 10) + 1;

    state_t                 state, state_nxt;
    logic                   accept;
    logic                   step;
    logic                   hd_range_ok;
    logic                   range_ok;
    logic [MEM_SUM_W-1:0]   mem_end;
    logic [HD_ADDR_W-1:0]   hd_addr;
    logic [MEM_ADDR_W-1:0]  mem_addr_q;
    logic [31:0]            buffer;
    logic [9:0]             remaining;
    logic [3:0]             wait_cnt;
    logic                   error_q;

    hd_addr_gen u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .load      (accept),
        .inc       (step),
        .load_addr ({sectorIn, trackIn}),
        .count     (wordCount),
        .addr      (hd_addr),
        .range_ok  (hd_range_ok)
    );

    assign mem_end  = MEM_SUM_W'(memBase) + MEM_SUM_W'(wordCount);
    assign range_ok = hd_range_ok && (mem_end <= MEM_SUM_W'(2 ** MEM_ADDR_W));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (!range_ok || wordCount == 10'd0) begin
                        state_nxt = DONE;
                    end else if (mode == MODE_STORE) begin
                        state_nxt = MR_ADDR;
                    end else begin
                        state_nxt = RD_ADDR;
                    end
                end
            end
            RD_ADDR: state_nxt = RD_WAIT;
            RD_WAIT: if (wait_cnt == 4'd0) state_nxt = MEM_WR;
            MEM_WR: begin
                step      = 1'b1;
                state_nxt = (remaining == 10'd1) ? DONE : RD_ADDR;
            end
            MR_ADDR: state_nxt = MR_WAIT;
            MR_WAIT: if (wait_cnt == 4'd0) state_nxt = HD_WR;
            HD_WR: begin
                step      = 1'b1;
                state_nxt = (remaining == 10'd1) ? DONE : MR_ADDR;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Wait counter is loaded in the address state so it reaches zero on the
    // last latency cycle, which is where the read data is captured.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr_q <= '0;
            buffer     <= '0;
            remaining  <= '0;
            wait_cnt   <= '0;
            error_q    <= 1'b0;
        end else begin
            if (accept) begin
                mem_addr_q <= memBase;
                remaining  <= wordCount;
                error_q    <= !range_ok;
            end
            case (state)
                RD_ADDR: wait_cnt <= 4'(HD_LAT - 1);
                MR_ADDR: wait_cnt <= 4'(MEM_LAT - 1);
                RD_WAIT: begin
                    if (wait_cnt == 4'd0) buffer <= hdDataR;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                MR_WAIT: begin
                    if (wait_cnt == 4'd0) buffer <= memDataR;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                MEM_WR, HD_WR: begin
                    mem_addr_q <= mem_addr_q + MEM_ADDR_W'(1);
                    remaining  <= remaining - 10'd1;
                end
                default: ;
            endcase
        end
    end

    assign hdSector = hd_addr[HD_ADDR_W-1:TRACK_W];
    assign hdTrack  = hd_addr[TRACK_W-1:0];
    assign hdDataW  = buffer;
    assign memDataW = buffer;
    assign memAddr  = mem_addr_q;
    assign hdFlag   = (state == HD_WR);
    assign memWe    = (state == MEM_WR);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign error    = error_q;

endmodule

// File: tb/tb_hd_transfer_ctrl.sv
// Directed bench for hd_transfer_ctrl with behavioural HD (latency 2) and
// memory (latency 1) models.
module tb_hd_transfer_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [3:0]  sectorIn;
    logic [9:0]  trackIn;
    logic [7:0]  memBase;
    logic [9:0]  wordCount;
    logic [3:0]  hdSector;
    logic [9:0]  hdTrack;
    logic [31:0] hdDataW;
    logic        hdFlag;
    logic [31:0] hdDataR;
    logic [7:0]  memAddr;
    logic [31:0] memDataW;
    logic        memWe;
    logic [31:0] memDataR;
    logic        busy;
    logic        done;
    logic        error;

    logic [31:0] mem [256];
    logic [31:0] hd  [16384];
    logic [31:0] hd_p1;
    int          we_cnt;
    int          flag_cnt;
    int          both_cnt;

    logic        pre_mem;
    logic        pre_hd;
    logic [13:0] pre_addr;
    logic [31:0] pre_data;

    int total;
    int bad;

    hd_transfer_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .sectorIn  (sectorIn),
        .trackIn   (trackIn),
        .memBase   (memBase),
        .wordCount (wordCount),
        .hdSector  (hdSector),
        .hdTrack   (hdTrack),
        .hdDataW   (hdDataW),
        .hdFlag    (hdFlag),
        .hdDataR   (hdDataR),
        .memAddr   (memAddr),
        .memDataW  (memDataW),
        .memWe     (memWe),
        .memDataR  (memDataR),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    initial begin
        we_cnt   = 0;
        flag_cnt = 0;
        both_cnt = 0;
    end

    always @(posedge clock) begin
        if (memWe)   mem[memAddr] <= memDataW;
        if (hdFlag)  hd[{hdSector, hdTrack}] <= hdDataW;
        if (pre_mem) mem[pre_addr[7:0]] <= pre_data;
        if (pre_hd)  hd[pre_addr] <= pre_data;
        memDataR <= mem[memAddr];
        hd_p1    <= hd[{hdSector, hdTrack}];
        hdDataR  <= hd_p1;
        if (memWe)           we_cnt   <= we_cnt + 1;
        if (hdFlag)          flag_cnt <= flag_cnt + 1;
        if (memWe && hdFlag) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic to_hd, input logic [13:0] a, input logic [31:0] d);
        @(negedge clock);
        pre_hd   = to_hd;
        pre_mem  = !to_hd;
        pre_addr = a;
        pre_data = d;
        @(negedge clock);
        pre_hd  = 1'b0;
        pre_mem = 1'b0;
    endtask

    // Returns the cycle (1 = first cycle after the start edge) in which done is seen.
    // A nonzero inj pulses a conflicting start in that cycle.
    task automatic run_xfer(input logic md, input logic [3:0] sec, input logic [9:0] trk,
                            input logic [7:0] base, input logic [9:0] cnt, input int inj,
                            output int cyc);
        @(negedge clock);
        start = 1'b1; mode = md; sectorIn = sec; trackIn = trk;
        memBase = base; wordCount = cnt;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            if (cyc == inj) begin
                start = 1'b1; mode = ~md; sectorIn = 4'd0; trackIn = 10'd0;
                memBase = 8'h00; wordCount = 10'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 200) chk("done_timeout", 32'(cyc), 32'd0);
        @(negedge clock);
        chk("done_one_cycle", {30'd0, done, busy}, 32'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ctl"}, {26'd0, busy, done, error, hdFlag, memWe, 1'b0}, 32'd0);
        chk({tag, "_memAddr"}, {24'd0, memAddr}, 32'd0);
        chk({tag, "_hdAddr"}, {18'd0, hdSector, hdTrack}, 32'd0);
        chk({tag, "_hdDataW"}, hdDataW, 32'd0);
        chk({tag, "_memDataW"}, memDataW, 32'd0);
    endtask

    initial begin
        int cyc;
        int w0, f0;
        total = 0; bad = 0;
        reset = 1'b1; start = 1'b0; mode = 1'b0; sectorIn = '0; trackIn = '0;
        memBase = '0; wordCount = '0; pre_mem = 1'b0; pre_hd = 1'b0;
        pre_addr = '0; pre_data = '0;
        repeat (3) @(negedge clock);
        chk_zero_outputs("reset");
        reset = 1'b0;

        // LOAD 3 words from sector 0 tracks 5..7
        for (int i = 5; i <= 7; i++) preload(1'b1, 14'(i), 32'hA0000000 + 32'(i));
        w0 = we_cnt; f0 = flag_cnt;
        run_xfer(1'b0, 4'd0, 10'd5, 8'h10, 10'd3, 0, cyc);
        chk("load_done_cycle", 32'(cyc), 32'd13);
        chk("load_mem10", mem[8'h10], 32'hA0000005);
        chk("load_mem11", mem[8'h11], 32'hA0000006);
        chk("load_mem12", mem[8'h12], 32'hA0000007);
        chk("load_we_pulses", 32'(we_cnt - w0), 32'd3);
        chk("load_no_flag", 32'(flag_cnt - f0), 32'd0);
        chk("load_error", {31'd0, error}, 32'd0);

        // same LOAD to 0x40 with a conflicting start while busy
        w0 = we_cnt; f0 = flag_cnt;
        run_xfer(1'b0, 4'd0, 10'd5, 8'h40, 10'd3, 5, cyc);
        chk("busy_start_cycle", 32'(cyc), 32'd13);
        chk("busy_start_mem40", mem[8'h40], 32'hA0000005);
        chk("busy_start_mem42", mem[8'h42], 32'hA0000007);
        chk("busy_start_we", 32'(we_cnt - w0), 32'd3);
        chk("busy_start_flag", 32'(flag_cnt - f0), 32'd0);

        // STORE 2 words across the track wrap
        preload(1'b0, 14'h20, 32'h12345678);
        preload(1'b0, 14'h21, 32'hCAFEBABE);
        w0 = we_cnt; f0 = flag_cnt;
        run_xfer(1'b1, 4'd2, 10'd1023, 8'h20, 10'd2, 0, cyc);
        chk("store_done_cycle", 32'(cyc), 32'd7);
        chk("store_hd_2_1023", hd[{4'd2, 10'd1023}], 32'h12345678);
        chk("store_hd_3_0", hd[{4'd3, 10'd0}], 32'hCAFEBABE);
        chk("store_flag_pulses", 32'(flag_cnt - f0), 32'd2);
        chk("store_no_we", 32'(we_cnt - w0), 32'd0);

        // HD range error, sticky until next accepted start
        w0 = we_cnt; f0 = flag_cnt;
        run_xfer(1'b0, 4'd15, 10'd1020, 8'h00, 10'd5, 0, cyc);
        chk("hd_range_cycle", 32'(cyc), 32'd1);
        chk("hd_range_error", {31'd0, error}, 32'd1);
        chk("hd_range_strobes", 32'((we_cnt - w0) + (flag_cnt - f0)), 32'd0);

        // zero-length request clears error
        run_xfer(1'b0, 4'd0, 10'd0, 8'h00, 10'd0, 0, cyc);
        chk("zero_cycle", 32'(cyc), 32'd1);
        chk("zero_error", {31'd0, error}, 32'd0);
        chk("zero_strobes", 32'((we_cnt - w0) + (flag_cnt - f0)), 32'd0);

        // memory range error: 0xFE + 3 > 256
        run_xfer(1'b1, 4'd0, 10'd0, 8'hFE, 10'd3, 0, cyc);
        chk("mem_range_cycle", 32'(cyc), 32'd1);
        chk("mem_range_error", {31'd0, error}, 32'd1);
        chk("mem_range_strobes", 32'((we_cnt - w0) + (flag_cnt - f0)), 32'd0);

        // HD boundary: block ends exactly at the last disk word
        w0 = we_cnt;
        run_xfer(1'b0, 4'd15, 10'd1020, 8'h50, 10'd4, 0, cyc);
        chk("hd_edge_cycle", 32'(cyc), 32'd17);
        chk("hd_edge_error", {31'd0, error}, 32'd0);
        chk("hd_edge_we", 32'(we_cnt - w0), 32'd4);

        // reset in RD_WAIT of word 2 of a 4-word LOAD
        for (int i = 0; i < 4; i++) preload(1'b1, {4'd1, 10'(i)}, 32'hB0000000 + 32'(i));
        preload(1'b0, 14'h61, 32'hDEADBEEF);
        w0 = we_cnt;
        @(negedge clock);
        start = 1'b1; mode = 1'b0; sectorIn = 4'd1; trackIn = 10'd0;
        memBase = 8'h60; wordCount = 10'd4;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk_zero_outputs("mid_reset");
        reset = 1'b0;
        chk("mid_reset_word1", mem[8'h60], 32'hB0000000);
        chk("mid_reset_word2", mem[8'h61], 32'hDEADBEEF);
        chk("mid_reset_we", 32'(we_cnt - w0), 32'd1);
        run_xfer(1'b0, 4'd1, 10'd0, 8'h60, 10'd4, 0, cyc);
        chk("restart_cycle", 32'(cyc), 32'd17);
        chk("restart_mem61", mem[8'h61], 32'hB0000001);
        chk("restart_mem63", mem[8'h63], 32'hB0000003);

        chk("no_overlap", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
